// File: rtl/seq_detect_param_if.sv
// Control/status bundle between a serial front-end and the sequence detector.
// The front-end side is the master; the detector is the slave.
interface seq_detect_param_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) ();
   logic               en;
   logic               w;
   logic               overlap;
   logic               pat_load;
   logic [PAT_LEN-1:0] pat_in;
   logic               cnt_clr;
   logic               z;
   logic [CNT_W-1:0]   match_cnt;
   logic               armed;

   modport master (
      output en, w, overlap, pat_load, pat_in, cnt_clr,
      input  z, match_cnt, armed
   );

   modport slave (
      input  en, w, overlap, pat_load, pat_in, cnt_clr,
      output z, match_cnt, armed
   );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with overlap control, optional
// registered match output and a saturating match counter.
module seq_detect_param #(
   parameter int                 PAT_LEN   = 4,
   parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b0011,
   parameter int                 CNT_W     = 8,
   parameter bit                 REG_OUT   = 1'b0
) (
   input logic               clk,
   input logic               reset,
   seq_detect_param_if.slave bus
);

   localparam int                FILL_W   = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   // Detector state is the number of valid history bits held.
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILLING,
      ST_ARMED
   } fill_state_e;

   logic [PAT_LEN-2:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   fill_state_e        fill_state;
   logic [PAT_LEN-1:0] hist_w;
   logic               hit;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= PAT_RESET;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         cnt_q  <= cnt_d;
      end
   end

   // NOTE: every variable written in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      fill_state = ST_FILLING;
      if (fill_q == '0) begin
         fill_state = ST_EMPTY;
      end else if (fill_q == FILL_MAX) begin
         fill_state = ST_ARMED;
      end
   end

   // The candidate window is the stored history plus the bit on the wire.
   assign hist_w = {hist_q, bus.w};
   assign hit    = bus.en & ~bus.pat_load & (fill_state == ST_ARMED)
                 & (hist_w == pat_q);

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;

      if (bus.pat_load) begin
         pat_d  = bus.pat_in;
         fill_d = '0;
      end else if (bus.en) begin
         hist_d = hist_w[PAT_LEN-2:0];
         case (fill_state)
            ST_ARMED: begin
               if (hit && !bus.overlap) begin
                  fill_d = '0;
                  hist_d = '0;
               end
            end
            default: fill_d = fill_q + 1'b1;
         endcase
      end
   end

   // Clear beats a coincident hit so software sees a clean zero.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   generate
      if (REG_OUT) begin : g_reg_z
         logic z_q, z_d;

         assign z_d = hit;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               z_q <= 1'b0;
            end else begin
               z_q <= z_d;
            end
         end

         assign bus.z = z_q;
      end else begin : g_mealy_z
         assign bus.z = hit;
      end
   endgenerate

   assign bus.match_cnt = cnt_q;
   assign bus.armed     = (fill_state == ST_ARMED);

endmodule
